// File: rtl/key_capture_pkg.sv
// Shared types and helpers for the key code capture path.
package key_capture_pkg;

    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, RELEASE} kc_state_t;

    // Encoder Q is active-low, so the true index is its complement.
    function automatic logic [CODE_W-1:0] enc2idx(input logic [CODE_W-1:0] q);
        return ~q;
    endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
module code_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // Storage is not reset, so present zero while empty.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/key_code_capture.sv
// Synchronise and debounce the priority encoder outputs and queue one code per press.
// Optional KEY_DROP_CNT_EN adds a saturating drop_count of FIFO overflows.
module key_code_capture
    import key_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CODE_W-1:0]             enc_q,
    input  logic                          enc_gs,
    input  logic                          enc_eo,
    output logic [CODE_W-1:0]             code_data,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          err
`ifdef KEY_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_count
`endif
);

    localparam int unsigned CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned LAST_CNT = (DEBOUNCE_CYC > 1) ? DEBOUNCE_CYC - 2 : 0;
    // The cycle that enters SETTLE/RELEASE already counts as the first stable cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_CNT);

    logic [SYNC_STAGES-1:0]             gs_sync_q, eo_sync_q;
    logic [SYNC_STAGES-1:0][CODE_W-1:0] q_sync_q;
    logic                               gs_s, eo_s, pressed, illegal;
    logic [CODE_W-1:0]                  q_s, idx_s;

    kc_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] code_lat_q, code_lat_d, push_data;
    logic              fifo_push, fifo_full, fifo_empty, code_pop;
    logic              overflow_q, overflow_d, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gs_sync_q <= '1;
            eo_sync_q <= '1;
            q_sync_q  <= '1;
        end else begin
            gs_sync_q <= {gs_sync_q[SYNC_STAGES-2:0], enc_gs};
            eo_sync_q <= {eo_sync_q[SYNC_STAGES-2:0], enc_eo};
            q_sync_q  <= {q_sync_q[SYNC_STAGES-2:0], enc_q};
        end
    end

    assign gs_s    = gs_sync_q[SYNC_STAGES-1];
    assign eo_s    = eo_sync_q[SYNC_STAGES-1];
    assign q_s     = q_sync_q[SYNC_STAGES-1];
    assign idx_s   = enc2idx(q_s);
    assign illegal = !gs_s && !eo_s;
    // An illegal GS/EO combination is treated as "no key pressed".
    assign pressed = !gs_s && eo_s;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_lat_d = code_lat_q;
        fifo_push  = 1'b0;
        push_data  = code_lat_q;
        unique case (state_q)
            IDLE: begin
                if (pressed) begin
                    cnt_d      = '0;
                    code_lat_d = idx_s;
                    if (DEBOUNCE_CYC == 1) begin
                        fifo_push = 1'b1;
                        push_data = idx_s;
                        state_d   = HOLD;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (idx_s != code_lat_q) begin
                    cnt_d      = '0;
                    code_lat_d = idx_s;
                end else if (cnt_q == CNT_LAST) begin
                    fifo_push = 1'b1;
                    state_d   = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!pressed) begin
                    cnt_d   = '0;
                    state_d = (DEBOUNCE_CYC == 1) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (pressed) begin
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign code_pop   = code_valid && code_ready;
    assign overflow_d = fifo_push && fifo_full && !code_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            code_lat_q <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_lat_q <= code_lat_d;
            overflow_q <= overflow_d;
            err_q      <= err_q || illegal;
        end
    end

    code_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_data),
        .pop   (code_ready),
        .rdata (code_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign code_valid = !fifo_empty;
    assign overflow   = overflow_q;
    assign err        = err_q;

`ifdef KEY_DROP_CNT_EN
    logic [7:0] drop_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_q <= '0;
        end else if (overflow_d && drop_count_q != 8'hff) begin
            drop_count_q <= drop_count_q + 1'b1;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_key_code_capture.sv
// Directed bench for key_code_capture with a queue of expected codes.
module tb_key_code_capture;

    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned DEBOUNCE_CYC = 16;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned LAT          = SYNC_STAGES + DEBOUNCE_CYC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] enc_q;
    logic       enc_gs;
    logic       enc_eo;
    logic [2:0] code_data;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       err;
`ifdef KEY_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    key_code_capture #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_q      (enc_q),
        .enc_gs     (enc_gs),
        .enc_eo     (enc_eo),
        .code_data  (code_data),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .err        (err)
`ifdef KEY_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_fail  = 0;
    int ovf_cnt = 0;
    logic [2:0] exp_q [$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && overflow === 1'b1) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key_press(input logic [2:0] q);
        enc_q  = q;
        enc_gs = 1'b0;
        enc_eo = 1'b1;
    endtask

    task automatic key_idle();
        enc_q  = 3'b111;
        enc_gs = 1'b1;
        enc_eo = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed pop request expected empty scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(code_valid), 32'd1);
            check({tag, "_data"}, 32'(code_data), 32'(e));
        end
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int ovf0;
        logic [2:0] q;

        // Reset with the encoder idle.
        rst_n      = 1'b0;
        code_ready = 1'b0;
        key_idle();
        step(3);
        check("t1_rst_valid", 32'(code_valid), 32'd0);
        check("t1_rst_data", 32'(code_data), 32'd0);
        check("t1_rst_count", 32'(fifo_count), 32'd0);
        check("t1_rst_ovf", 32'(overflow), 32'd0);
        check("t1_rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step(5);
        check("t1_idle_count", 32'(fifo_count), 32'd0);
        check("t1_idle_err", 32'(err), 32'd0);
`ifdef KEY_DROP_CNT_EN
        check("t1_drop_count", 32'(drop_count), 32'd0);
`endif

        // Clean press of input 5 and pin-to-valid latency.
        key_press(3'b010);
        exp_q.push_back(3'd5);
        lat = 0;
        while (code_valid !== 1'b1 && lat < 100) begin
            step(1);
            lat++;
        end
        check("t2_latency", 32'(lat), 32'(LAT));
        step(12);
        check("t2_count_held", 32'(fifo_count), 32'd1);
        key_idle();
        step(30);
        check("t2_count_released", 32'(fifo_count), 32'd1);
        pop_check("t2_pop");
        check("t2_count_empty", 32'(fifo_count), 32'd0);

        // Bouncing press then a steady one.
        for (int i = 0; i < 3; i++) begin
            key_press(3'b100);
            step(5);
            key_idle();
            step(5);
        end
        check("t3_no_early_push", 32'(fifo_count), 32'd0);
        key_press(3'b100);
        exp_q.push_back(3'd3);
        step(20);
        check("t3_one_push", 32'(fifo_count), 32'd1);
        key_idle();
        step(30);
        check("t3_still_one", 32'(fifo_count), 32'd1);
        pop_check("t3_pop");

        // Five presses with the host stalled: the fifth is dropped.
        ovf0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            q = ~3'(i);
            key_press(q);
            if (i < 4) exp_q.push_back(3'(i));
            step(25);
            key_idle();
            step(25);
        end
        check("t4_ovf_pulses", 32'(ovf_cnt - ovf0), 32'd1);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        check("t4_head", 32'(code_data), 32'(exp_q[0]));
`ifdef KEY_DROP_CNT_EN
        check("t4_drop_count", 32'(drop_count), 32'd1);
`endif

        // Full FIFO: push and pop land on the same edge.
        ovf0 = ovf_cnt;
        key_press(3'b001);
        step(LAT - 1);
        check("t5_head_before", 32'(code_data), 32'(exp_q[0]));
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(3'd6);
        check("t5_count_kept", 32'(fifo_count), 32'd4);
        step(3);
        check("t5_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
        key_idle();
        step(30);
        for (int i = 0; i < 4; i++) pop_check("t5_drain");
        check("t5_count_empty", 32'(fifo_count), 32'd0);

        // Illegal GS/EO sets sticky err without pushing.
        enc_q  = 3'b110;
        enc_gs = 1'b0;
        enc_eo = 1'b0;
        step(30);
        check("t6_err_set", 32'(err), 32'd1);
        check("t6_no_push", 32'(fifo_count), 32'd0);
        key_idle();
        step(5);
        check("t6_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a debounce.
        key_press(3'b011);
        step(8);
        rst_n = 1'b0;
        #1;
        check("t6_async_err", 32'(err), 32'd0);
        check("t6_async_valid", 32'(code_valid), 32'd0);
        check("t6_async_count", 32'(fifo_count), 32'd0);
        check("t6_async_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        key_idle();
        step(3);
        rst_n = 1'b1;
        step(30);
        check("t6_post_count", 32'(fifo_count), 32'd0);
        check("t6_post_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
